// File: rtl/character_plotter_if.sv
// character_plotter_if
// Groups the position handshake and the VGA adapter pixel bus of one
// character_plotter instance.
//   pos_valid  : position on xPos_in/yPos_in is offered this cycle
//   pos_ready  : plotter is idle and will take the position
//   xPos_in    : sprite left edge, pixels from the left
//   yPos_in    : sprite bottom edge, pixels above the screen bottom
//   vga_x      : pixel x to the VGA adapter
//   vga_y      : pixel y to the VGA adapter (0 = top row)
//   vga_colour : pixel colour
//   vga_plot   : write strobe, one pixel per high cycle
//   frame_done : one-cycle pulse after the last pixel of a frame
// Modports: master = position producer / pixel consumer side,
//           slave  = the plotter itself.
interface character_plotter_if;
  logic       pos_valid;
  logic       pos_ready;
  logic [9:0] xPos_in;
  logic [8:0] yPos_in;
  logic [9:0] vga_x;
  logic [8:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       frame_done;

  modport master (
    output pos_valid, xPos_in, yPos_in,
    input  pos_ready, vga_x, vga_y, vga_colour, vga_plot, frame_done
  );

  modport slave (
    input  pos_valid, xPos_in, yPos_in,
    output pos_ready, vga_x, vga_y, vga_colour, vga_plot, frame_done
  );
endinterface

// File: rtl/character_plotter.sv
// character_plotter
// Takes a player position (ground-up coordinates) and renders the player
// sprite into the VGA adapter framebuffer, one pixel per clock. The box drawn
// for the previous position is first erased in BG_COLOUR, then the box at the
// new position is drawn in FG_COLOUR.
// Ports:
//   CLOCK_50 : system clock, all logic on the rising edge
//   reset    : asynchronous, active-high
//   bus      : character_plotter_if.slave (position handshake + VGA pixel bus)
// Configuration macro: SPRITE_OUTLINE_EN -- when defined, the draw pass only
// plots the border of the box (erase still clears the whole box); frame
// timing is identical either way.
module character_plotter #(
  parameter int         SPRITE_W  = 8,
  parameter int         SPRITE_H  = 16,
  parameter int         SCREEN_W  = 640,
  parameter int         SCREEN_H  = 480,
  parameter logic [2:0] FG_COLOUR = 3'b100,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input logic                 CLOCK_50,
  input logic                 reset,
  character_plotter_if.slave  bus
);

  localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(SPRITE_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(SPRITE_H - 1);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

  state_t        state, next_state;
  logic [CW-1:0] col, col_next;
  logic [RW-1:0] row, row_next;
  logic [9:0]    old_x, new_x;
  logic [8:0]    old_y, new_y;
  logic          has_old;
  logic          transfer;
  logic          plot_next;
  logic          done_next;

  logic [9:0]         base_x;
  logic [8:0]         base_y;
  logic [2:0]         colour;
  logic [10:0]        pix_x;
  logic signed [10:0] pix_y;
  logic               on_screen;
  logic               shape_hit;

  // The cycle carrying frame_done is already IDLE, but the caller should only
  // see ready from the following cycle, so it is masked out here.
  assign bus.pos_ready = (state == IDLE) && !bus.frame_done;
  assign transfer      = bus.pos_valid && bus.pos_ready;

  // Pixel generator: picks the box being worked on, converts the ground-up
  // row into a top-down screen row and decides whether this pixel is
  // actually written. Clipped pixels still consume a cycle.
  always_comb begin
    base_x = new_x;
    base_y = new_y;
    colour = FG_COLOUR;
    if (state == ERASE) begin
      base_x = old_x;
      base_y = old_y;
      colour = BG_COLOUR;
    end
    pix_x = {1'b0, base_x} + 11'(col);
    pix_y = $signed(11'(SCREEN_H - 1)) - $signed({2'b00, base_y} + 11'(row));
    on_screen = (pix_x < 11'(SCREEN_W)) && (pix_y >= 11'sd0) &&
                (pix_y < $signed(11'(SCREEN_H)));
`ifdef SPRITE_OUTLINE_EN
    shape_hit = (state == ERASE) || (row == '0) || (row == ROW_LAST) ||
                (col == '0) || (col == COL_LAST);
`else
    shape_hit = 1'b1;
`endif
  end

  // Next-state logic: column is the inner counter, row the outer one. The
  // erase pass rolls straight into the draw pass with no gap cycle, and a
  // repeat of the current position skips both passes.
  always_comb begin
    next_state = state;
    col_next   = col;
    row_next   = row;
    plot_next  = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        col_next = '0;
        row_next = '0;
        if (transfer) begin
          if (has_old && bus.xPos_in == old_x && bus.yPos_in == old_y)
            next_state = DONE;
          else if (has_old)
            next_state = ERASE;
          else
            next_state = DRAW;
        end
      end
      ERASE, DRAW: begin
        plot_next = on_screen && shape_hit;
        if (col == COL_LAST) begin
          col_next = '0;
          if (row == ROW_LAST) begin
            row_next   = '0;
            next_state = (state == ERASE) ? DRAW : DONE;
          end else begin
            row_next = row + RW'(1);
          end
        end else begin
          col_next = col + CW'(1);
        end
      end
      DONE: begin
        done_next  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State and pixel counters.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= next_state;
      col   <= col_next;
      row   <= row_next;
    end
  end

  // Registered VGA outputs and position bookkeeping. The pixel for the
  // current counter value appears on the bus one cycle later; the colour is
  // only updated on real writes so it holds while nothing is plotted.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      bus.vga_x      <= '0;
      bus.vga_y      <= '0;
      bus.vga_colour <= '0;
      bus.vga_plot   <= 1'b0;
      bus.frame_done <= 1'b0;
      old_x          <= '0;
      old_y          <= '0;
      new_x          <= '0;
      new_y          <= '0;
      has_old        <= 1'b0;
    end else begin
      bus.vga_plot   <= plot_next;
      bus.frame_done <= done_next;
      if (state == ERASE || state == DRAW) begin
        bus.vga_x <= pix_x[9:0];
        bus.vga_y <= pix_y[8:0];
      end
      if (plot_next)
        bus.vga_colour <= colour;
      if (transfer) begin
        new_x <= bus.xPos_in;
        new_y <= bus.yPos_in;
      end
      if (state == DONE) begin
        old_x   <= new_x;
        old_y   <= new_y;
        has_old <= 1'b1;
      end
    end
  end

endmodule
